// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline sequencer: stall encodings, FSM states,
// exception codes and the redirect-target helper.
package pipe_ctrl_pkg;

  // FSM states: normal issue, one-cycle flush pulse, one-cycle refill bubble
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_BUBBLE = 2'd2
  } state_e;

  localparam logic FLUSH_ON  = 1'b1;
  localparam logic FLUSH_OFF = 1'b0;

  localparam logic [31:0] EXC_NONE = 32'h0000_0000;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  // Stall vector bits: [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  // ERET returns to the saved EPC; every other exception goes to the fixed vector
  function automatic logic [31:0] redirect_target(
    input logic [31:0] excepttype,
    input logic [31:0] epc,
    input logic [31:0] exc_vector
  );
    return (excepttype == EXC_ERET) ? epc : exc_vector;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_encoder.sv
// Priority encoder from the per-stage hold requests to the 6-bit stall vector.
// A stage that holds also freezes every stage in front of it, so only the
// highest-priority (furthest down the pipe) request is encoded.
module pipe_ctrl_stall_encoder
  import pipe_ctrl_pkg::*;
(
  input  logic       i_req_id,
  input  logic       i_req_ex,
  input  logic       i_req_mem,
  output logic [5:0] o_stall
);

  // MEM > EX > ID; the vector is a single encoding, never a merge of several
  always_comb begin
    // NOTE: assigning a default before any branch keeps every path driven,
    // so no latch can be inferred from a missing else.
    o_stall = STALL_NONE;
    if (i_req_mem)      o_stall = STALL_MEM;
    else if (i_req_ex)  o_stall = STALL_EX;
    else if (i_req_id)  o_stall = STALL_ID;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core: merges stage stall requests,
// turns a MEM-stage exception into a one-cycle registered flush with the
// redirect target, and counts stalled cycles (saturating).
// Optional build macro CTRL_WATCHDOG_EN adds a consecutive-stall watchdog
// that forces a flush to WDT_VECTOR and raises a sticky timeout flag.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int          CNT_W      = 16
`ifdef CTRL_WATCHDOG_EN
  ,
  parameter int          WDT_LIMIT  = 1024,
  parameter logic [31:0] WDT_VECTOR = 32'h0000_0040
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic [31:0]      excepttype_i,
  input  logic [31:0]      cp0_epc_i,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             wdt_timeout_o
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_flush;
  logic [31:0]      r_new_pc;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [5:0]       w_req_stall;
  logic             w_exc;
  logic             w_flush_nxt;
  logic [31:0]      w_new_pc_nxt;
  logic             w_wdt_hit;

  pipe_ctrl_stall_encoder u_stall_encoder (
    .i_req_id  (stallreq_id),
    .i_req_ex  (stallreq_ex),
    .i_req_mem (stallreq_mem),
    .o_stall   (w_req_stall)
  );

  assign w_exc = (excepttype_i != EXC_NONE);

`ifdef CTRL_WATCHDOG_EN
  localparam int RUN_W = (WDT_LIMIT > 1) ? $clog2(WDT_LIMIT) : 1;

  logic [RUN_W-1:0] r_run_cnt;
  logic             r_wdt_timeout;

  // The limit is reached on the cycle that would be the WDT_LIMIT-th stall in
  // a row; an exception in that cycle zeroes stall but still trips the flag.
  assign w_wdt_hit = (r_state == ST_RUN) && w_req_stall[0] &&
                     (r_run_cnt == RUN_W'(WDT_LIMIT - 1));

  // Consecutive-stall run length and sticky timeout flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run_cnt     <= '0;
      r_wdt_timeout <= 1'b0;
    end else begin
      if (stall[0] && !w_wdt_hit) r_run_cnt <= r_run_cnt + RUN_W'(1);
      else                        r_run_cnt <= '0;
      if (w_wdt_hit) r_wdt_timeout <= 1'b1;
    end
  end

  assign wdt_timeout_o = r_wdt_timeout;
  assign w_new_pc_nxt  = w_exc ? redirect_target(excepttype_i, cp0_epc_i, EXC_VECTOR)
                               : WDT_VECTOR;
`else
  assign w_wdt_hit     = 1'b0;
  assign wdt_timeout_o = 1'b0;
  assign w_new_pc_nxt  = redirect_target(excepttype_i, cp0_epc_i, EXC_VECTOR);
`endif

  // Next-state, stall gating and flush request
  always_comb begin
    w_state_nxt = r_state;
    stall       = STALL_NONE;
    w_flush_nxt = FLUSH_OFF;
    unique case (r_state)
      ST_RUN: begin
        if (w_exc) begin
          // Exception wins over every hold request
          w_flush_nxt = FLUSH_ON;
          w_state_nxt = ST_FLUSH;
        end else begin
          stall = w_req_stall;
          if (w_wdt_hit) begin
            w_flush_nxt = FLUSH_ON;
            w_state_nxt = ST_FLUSH;
          end
        end
      end
      ST_FLUSH:  w_state_nxt = ST_BUBBLE;
      ST_BUBBLE: w_state_nxt = ST_RUN;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  // State register, registered flush pulse and latched redirect target
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_RUN;
      r_flush  <= FLUSH_OFF;
      r_new_pc <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register here see the
      // pre-edge values, regardless of statement order.
      r_state <= w_state_nxt;
      r_flush <= w_flush_nxt;
      if (w_flush_nxt) r_new_pc <= w_new_pc_nxt;
    end
  end

  // Saturating count of cycles with the PC held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (stall[0] && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign flush     = r_flush;
  assign new_pc    = r_new_pc;
  assign stall_cnt = r_stall_cnt;

endmodule
